sub_serial_16bit: RTL

//  Multi-cycle 16-bit subtract/compare unit for the Execute stage. Supplies the

---
 rtl/sub_serial_16bit_pkg.sv | 25 ++
 rtl/sub_serial_16bit_if.sv | 28 ++
 rtl/sub_serial_16bit_slice.sv | 36 +++
 rtl/sub_serial_16bit.sv | 132 +++++++++++++
 4 files changed

// File: rtl/sub_serial_16bit_pkg.sv
// rtl/sub_serial_16bit_pkg.sv - shared Execute encodings for the serial subtract unit
package sub_serial_16bit_pkg;

  typedef enum logic [1:0] {
    OP_SUB     = 2'b00,
    OP_SUBS    = 2'b01,
    OP_CMP     = 2'b10,
    OP_SUB_ALT = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;

  // Saturation value for a 16-bit signed overflow, chosen by the minuend sign.
  function automatic logic [15:0] sat_value(input logic neg);
    return neg ? SAT_NEG : SAT_POS;
  endfunction

endpackage

// File: rtl/sub_serial_16bit_if.sv
// rtl/sub_serial_16bit_if.sv - operand/result handshake bundle for the serial subtract unit
interface sub_serial_16bit_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_n;
  logic             flag_z;
  logic             flag_v;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flag_n, flag_z, flag_v
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flag_n, flag_z, flag_v
  );

endinterface

// File: rtl/sub_serial_16bit_slice.sv
// rtl/sub_serial_16bit_slice.sv - combinational NIB-bit a + ~b + cin with lookahead carry
module nibble_sub_slice #(
  parameter int NIB = 4
) (
  input  logic [NIB-1:0] a,
  input  logic [NIB-1:0] nb,
  input  logic           cin,
  output logic [NIB-1:0] sum,
  output logic           cout
);

  logic [NIB-1:0] g;
  logic [NIB-1:0] p;
  logic [NIB:0]   c;
  logic           pp;

  // Each carry is the flattened OR of generate terms, no ripple through c[].
  always_comb begin
    g    = a & nb;
    p    = a ^ nb;
    c    = '0;
    pp   = 1'b1;
    c[0] = cin;
    for (int i = 0; i < NIB; i++) begin
      pp = 1'b1;
      for (int j = i; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pp & g[j]);
        pp     = pp & p[j];
      end
      c[i+1] = c[i+1] | (pp & cin);
    end
    sum  = p ^ c[NIB-1:0];
    cout = c[NIB];
  end

endmodule

// File: rtl/sub_serial_16bit.sv
// rtl/sub_serial_16bit.sv - multi-cycle nibble-serial subtract/compare unit with N/Z/V flags
module sub_serial_16bit
  import sub_serial_16bit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NIB   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  sub_serial_16bit_if.slave bus
);

  localparam int NSTEPS = WIDTH / NIB;
  localparam int STEP_W = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEPS - 1);

  state_e               state;
  op_e                  op_q;
  logic [STEP_W-1:0]    step;
  logic                 carry;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     a_sh;
  logic [WIDTH-1:0]     nb_sh;
  logic                 b_msb;
  logic [WIDTH-NIB-1:0] diff;
  logic [WIDTH-1:0]     result_q;
  logic                 n_q;
  logic                 z_q;
  logic                 v_q;
  logic                 out_valid_q;

  logic [NIB-1:0]       sum;
  logic                 cout;
  logic [WIDTH-1:0]     d_fin;
  logic [WIDTH-1:0]     res_fin;
  logic                 v_fin;
  logic                 n_fin;
  logic                 z_fin;

  nibble_sub_slice #(.NIB(NIB)) u_slice (
    .a    (a_sh[NIB-1:0]),
    .nb   (nb_sh[NIB-1:0]),
    .cin  (carry),
    .sum  (sum),
    .cout (cout)
  );

  // Final-step view: the nibble being produced now is the top of the raw diff.
  always_comb begin
    d_fin   = {sum, diff};
    v_fin   = (a_q[WIDTH-1] ^ b_msb) & (a_q[WIDTH-1] ^ d_fin[WIDTH-1]);
    res_fin = d_fin;
    if (op_q == OP_SUBS && v_fin) begin
      res_fin = {a_q[WIDTH-1], {(WIDTH-1){~a_q[WIDTH-1]}}};
    end
    n_fin = res_fin[WIDTH-1];
    z_fin = (res_fin == '0);
    if (op_q == OP_CMP) begin
      res_fin = a_q;
      n_fin   = d_fin[WIDTH-1];
      z_fin   = (d_fin == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      op_q        <= OP_SUB;
      step        <= '0;
      carry       <= 1'b0;
      a_q         <= '0;
      a_sh        <= '0;
      nb_sh       <= '0;
      b_msb       <= 1'b0;
      diff        <= '0;
      result_q    <= '0;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
      v_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state       <= S_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            op_q  <= op_e'(bus.op);
            a_q   <= bus.a;
            a_sh  <= bus.a;
            nb_sh <= ~bus.b;
            b_msb <= bus.b[WIDTH-1];
            carry <= 1'b1;
            step  <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          diff  <= {sum, diff[WIDTH-NIB-1:NIB]};
          a_sh  <= a_sh >> NIB;
          nb_sh <= nb_sh >> NIB;
          carry <= cout;
          step  <= step + 1'b1;
          if (step == LAST_STEP) begin
            result_q    <= res_fin;
            n_q         <= n_fin;
            z_q         <= z_fin;
            v_q         <= v_fin;
            out_valid_q <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = rst_n & (state == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flag_n    = n_q;
  assign bus.flag_z    = z_q;
  assign bus.flag_v    = v_q;

endmodule
